register_bank: RTL and testbench

- Two-entry, 8-bit general-purpose register file for the non-pipelined 8-bit processor datapath.
- Provides two asynchronous (combinational) read ports and one synchronous write port.
- Write data comes from the data-memory/writeback path (data_memory_out).
- Destination register select is driven by the control signal reg_dst.

---
 rtl/register_bank_if.sv | 24 ++
 rtl/register_bank.sv | 43 ++++
 tb/tb_register_bank.sv | 117 +++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// Register-bank port bundle: read selects, write control/data and both read results.
// master drives selects and write data; slave (the bank) returns the read data.
interface register_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic              reg_write;
  logic              reg_dst;
  logic [DATA_W-1:0] data_memory_out;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2_muxop;

  modport master (
    output read_reg1, read_reg2, reg_write, reg_dst, data_memory_out,
    input  read_data1, read_data2_muxop
  );

  modport slave (
    input  read_reg1, read_reg2, reg_write, reg_dst, data_memory_out,
    output read_data1, read_data2_muxop
  );
endinterface

// File: rtl/register_bank.sv
// Two-read / one-write register file for the 8-bit datapath; combinational reads.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  register_bank_if.slave       rb
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [ADDR_W-1:0]               waddr;

  // reg_dst picks which read select doubles as the write destination
  always_comb waddr = rb.reg_dst ? rb.read_reg2 : rb.read_reg1;

  always_comb begin
    regs_d = regs_q;
    if (reset)             regs_d = '0;
    else if (rb.reg_write) regs_d[waddr] = rb.data_memory_out;
  end

  always_ff @(posedge clk) regs_q <= regs_d;

`ifdef REG_BANK_BYPASS_EN
  logic wr_live;
  always_comb wr_live = rb.reg_write && !reset;

  always_comb begin
    rb.read_data1       = regs_q[rb.read_reg1];
    rb.read_data2_muxop = regs_q[rb.read_reg2];
    if (wr_live && rb.read_reg1 == waddr) rb.read_data1       = rb.data_memory_out;
    if (wr_live && rb.read_reg2 == waddr) rb.read_data2_muxop = rb.data_memory_out;
  end
`else
  always_comb begin
    rb.read_data1       = regs_q[rb.read_reg1];
    rb.read_data2_muxop = regs_q[rb.read_reg2];
  end
`endif
endmodule

// File: tb/tb_register_bank.sv
// Directed test-plan steps followed by random traffic, checked against an array model.
module tb_register_bank;
  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  register_bank_if #(.DATA_W(8), .ADDR_W(1)) bus ();

  register_bank #(.DATA_W(8), .ADDR_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .rb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [2];
  bit         mem_ok = 0;
  bit         c_rst, c_we, c_dst;
  logic       c_a1, c_a2;
  logic [7:0] c_d;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic idx);
    logic wa;
    wa = c_dst ? c_a2 : c_a1;
`ifdef REG_BANK_BYPASS_EN
    if (c_we && !c_rst && idx == wa) return c_d;
`endif
    return mem[idx];
  endfunction

  task automatic drive(input bit rst, we, dst, input logic a1, a2, input logic [7:0] d);
    c_rst = rst; c_we = we; c_dst = dst; c_a1 = a1; c_a2 = a2; c_d = d;
    reset = rst; bus.reg_write = we; bus.reg_dst = dst;
    bus.read_reg1 = a1; bus.read_reg2 = a2; bus.data_memory_out = d;
  endtask

  // One clock: check reads before the edge, update the model at the edge, check after.
  task automatic cyc(input bit rst, we, dst, input logic a1, a2, input logic [7:0] d);
    drive(rst, we, dst, a1, a2, d);
    #2;
    if (mem_ok) begin
      chk("pre_rd1", bus.read_data1, exp_rd(a1));
      chk("pre_rd2", bus.read_data2_muxop, exp_rd(a2));
    end
    @(posedge clk);
    if (rst) begin
      mem[0] = 8'h00; mem[1] = 8'h00; mem_ok = 1;
    end else if (we && mem_ok) begin
      mem[dst ? a2 : a1] = d;
    end
    #1;
    if (mem_ok) begin
      chk("post_rd1", bus.read_data1, exp_rd(a1));
      chk("post_rd2", bus.read_data2_muxop, exp_rd(a2));
    end
  endtask

  // Idle read of both registers in both port orders, no edge.
  task automatic peek(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    drive(0, 0, 0, 1'b0, 1'b1, 8'h5A);
    #1;
    chk({tag, "_p1r0"}, bus.read_data1, e0);
    chk({tag, "_p2r1"}, bus.read_data2_muxop, e1);
    drive(0, 0, 0, 1'b1, 1'b0, 8'h5A);
    #1;
    chk({tag, "_p1r1"}, bus.read_data1, e1);
    chk({tag, "_p2r0"}, bus.read_data2_muxop, e0);
  endtask

  initial begin
    drive(1, 1, 0, 1'b0, 1'b1, 8'hFF);
    // reset wins over a simultaneous write
    cyc(1, 1, 0, 1'b0, 1'b1, 8'hFF);
    cyc(1, 1, 1, 1'b0, 1'b1, 8'hFF);
    peek("reset", 8'h00, 8'h00);

    cyc(0, 1, 0, 1'b0, 1'b1, 8'h02);
    peek("wr_r0", 8'h02, 8'h00);
    cyc(0, 1, 1, 1'b0, 1'b1, 8'h17);
    peek("wr_r1", 8'h02, 8'h17);

    for (int i = 0; i < 4; i++) cyc(0, 0, i[0], i[1], ~i[0], 8'hC7);
    peek("wr_off", 8'h02, 8'h17);

    drive(0, 0, 0, 1'b1, 1'b1, 8'h00);
    #1;
    chk("dual_rd1", bus.read_data1, 8'h17);
    chk("dual_rd2", bus.read_data2_muxop, 8'h17);
    cyc(0, 1, 1, 1'b1, 1'b1, 8'h1F);
    peek("dual_wr", 8'h02, 8'h1F);

    cyc(0, 1, 0, 1'b0, 1'b1, 8'h03);
    chk("b2b_first", bus.read_data1, 8'h03);
    cyc(0, 1, 0, 1'b0, 1'b1, 8'h07);
    chk("b2b_second", bus.read_data1, 8'h07);
    peek("b2b", 8'h07, 8'h1F);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(15) == 0, $urandom_range(1), $urandom_range(1),
          $urandom_range(1), $urandom_range(1), 8'($urandom));
    peek("final", mem[0], mem[1]);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end
endmodule
